// File: rtl/mac_unit.sv
// -----------------------------------------------------------------------------
// mac_unit
//
// Single multiply-accumulate lane. On every rising edge with enable high, the
// full-precision product a_in*b_in is added into a registered accumulator.
// The clear input restarts the dot product. When clear and enable are both
// high, the current product becomes the first term of the new sum. Arithmetic
// is signed or unsigned (SIGNED). An out-of-range result either wraps or clamps
// (SATURATE). A sticky flag records any out-of-range result since the last
// clear.
//
// Parameters:
//   DATA_WIDTH  operand width
//   ACC_WIDTH   accumulator width, must be >= DATA_WIDTH
//   SIGNED      1 = two's-complement, 0 = unsigned
//   SATURATE    1 = clamp to range on overflow, 0 = wrap modulo 2^ACC_WIDTH
//
// Ports:
//   clk        in   rising-edge clock
//   reset      in   asynchronous active-low reset
//   clear      in   restart accumulation
//   enable     in   accumulate this cycle
//   a_in       in   multiplicand [DATA_WIDTH]
//   b_in       in   multiplier   [DATA_WIDTH]
//   accum_out  out  registered accumulator value [ACC_WIDTH]
//   overflow   out  sticky out-of-range flag
// -----------------------------------------------------------------------------
module mac_unit #(
    parameter int DATA_WIDTH = 32,
    parameter int ACC_WIDTH  = 32,
    parameter int SIGNED     = 0,
    parameter int SATURATE   = 0
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  clear,
    input  logic                  enable,
    input  logic [DATA_WIDTH-1:0] a_in,
    input  logic [DATA_WIDTH-1:0] b_in,
    output logic [ACC_WIDTH-1:0]  accum_out,
    output logic                  overflow
);

    localparam int  PROD_W  = 2 * DATA_WIDTH;
    // The sum is two bits wider than its widest operand. The extra bits hold
    // the carry and a sign bit, so the exact result never wraps internally.
    localparam int  SUM_W   = ((ACC_WIDTH > PROD_W) ? ACC_WIDTH : PROD_W) + 2;
    localparam bit  IS_SIGN = (SIGNED != 0);
    localparam bit  IS_SAT  = (SATURATE != 0);

    localparam logic [ACC_WIDTH-1:0] ACC_MAX = IS_SIGN ?
        {1'b0, {(ACC_WIDTH-1){1'b1}}} : {ACC_WIDTH{1'b1}};
    localparam logic [ACC_WIDTH-1:0] ACC_MIN = IS_SIGN ?
        {1'b1, {(ACC_WIDTH-1){1'b0}}} : {ACC_WIDTH{1'b0}};

    logic [PROD_W-1:0]    a_ext;
    logic [PROD_W-1:0]    b_ext;
    logic [PROD_W-1:0]    product;
    logic [SUM_W-1:0]     prod_ext;
    logic [SUM_W-1:0]     base_ext;
    logic [SUM_W-1:0]     exact_sum;
    logic [SUM_W-1:ACC_WIDTH-1] sign_region;
    logic                 above_range;
    logic                 below_range;
    logic                 out_of_range;
    logic [ACC_WIDTH-1:0] result;
    logic [ACC_WIDTH-1:0] accum_next;
    logic                 overflow_next;

    // Operands are extended to the product width before multiplying. The low
    // PROD_W bits of the product are then exact for both signed and unsigned
    // operands, and a single unsigned multiplier serves both modes.
    assign a_ext   = {{DATA_WIDTH{IS_SIGN & a_in[DATA_WIDTH-1]}}, a_in};
    assign b_ext   = {{DATA_WIDTH{IS_SIGN & b_in[DATA_WIDTH-1]}}, b_in};
    assign product = a_ext * b_ext;

    assign prod_ext = {{(SUM_W-PROD_W){IS_SIGN & product[PROD_W-1]}}, product};

    // A clear with enable starts a new sum from zero, not from the stored
    // value. A wrapped accumulator feeds the sum as stored, not as the exact
    // value that overflowed.
    assign base_ext = clear ? '0 :
        {{(SUM_W-ACC_WIDTH){IS_SIGN & accum_out[ACC_WIDTH-1]}}, accum_out};

    assign exact_sum = base_ext + prod_ext;

    // Signed: the result fits if every bit from ACC_WIDTH-1 upward equals the
    // sign. Unsigned: the result is never negative, so it fits if every bit
    // from ACC_WIDTH upward is zero.
    assign sign_region = exact_sum[SUM_W-1:ACC_WIDTH-1];

    always_comb begin
        // NOTE: every signal written in this block gets a value first, on all
        // paths, so no latch is inferred.
        above_range = 1'b0;
        below_range = 1'b0;
        if (IS_SIGN) begin
            above_range = ~exact_sum[SUM_W-1] & (|sign_region);
            below_range =  exact_sum[SUM_W-1] & ~(&sign_region);
        end else begin
            above_range = |exact_sum[SUM_W-1:ACC_WIDTH];
        end
    end

    assign out_of_range = above_range | below_range;

    always_comb begin
        result = exact_sum[ACC_WIDTH-1:0];
        if (IS_SAT && above_range) begin
            result = ACC_MAX;
        end else if (IS_SAT && below_range) begin
            result = ACC_MIN;
        end
    end

    always_comb begin
        accum_next    = accum_out;
        overflow_next = overflow;
        if (clear && enable) begin
            accum_next    = result;
            overflow_next = out_of_range;
        end else if (clear) begin
            accum_next    = '0;
            overflow_next = 1'b0;
        end else if (enable) begin
            accum_next    = result;
            overflow_next = overflow | out_of_range;
        end
    end

    // NOTE: state registers use non-blocking assignments. Every flop then
    // samples the values from before the edge, regardless of process order.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            accum_out <= '0;
            overflow  <= 1'b0;
        end else begin
            accum_out <= accum_next;
            overflow  <= overflow_next;
        end
    end

endmodule

// File: tb/tb_mac_unit.sv
// -----------------------------------------------------------------------------
// tb_mac_unit
//
// Four mac_unit lanes with 32-bit operands and accumulator:
//   lane 0: unsigned, wrap   lane 1: signed, saturate
//   lane 2: signed, wrap     lane 3: unsigned, saturate
// Stimulus drives one lane per cycle and pushes the hand-computed response
// into a queue. A monitor on the falling edge pops each entry and compares it
// against the selected lane.
// -----------------------------------------------------------------------------
module tb_mac_unit;

    localparam int N = 4;

    typedef struct {
        int          id;
        logic [31:0] acc;
        logic        ovf;
        string       name;
    } exp_t;

    logic        clk;
    logic        reset;
    logic        clear_s  [N];
    logic        enable_s [N];
    logic [31:0] a_s      [N];
    logic [31:0] b_s      [N];
    logic [31:0] acc_s    [N];
    logic        ovf_s    [N];

    exp_t sb[$];
    int   checks;
    int   errors;

    for (genvar g = 0; g < N; g++) begin : g_lane
        mac_unit #(
            .DATA_WIDTH (32),
            .ACC_WIDTH  (32),
            .SIGNED     ((g == 1 || g == 2) ? 1 : 0),
            .SATURATE   ((g == 1 || g == 3) ? 1 : 0)
        ) dut (
            .clk       (clk),
            .reset     (reset),
            .clear     (clear_s[g]),
            .enable    (enable_s[g]),
            .a_in      (a_s[g]),
            .b_in      (b_s[g]),
            .accum_out (acc_s[g]),
            .overflow  (ovf_s[g])
        );
    end

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Monitor: registered outputs are stable by the falling edge.
    initial begin
        checks = 0;
        errors = 0;
    end

    always @(negedge clk) begin
        if (sb.size() > 0) begin
            exp_t e;
            e = sb.pop_front();
            checks++;
            if (acc_s[e.id] !== e.acc || ovf_s[e.id] !== e.ovf) begin
                errors++;
                $display("FAIL %s: lane%0d got accum_out=%h overflow=%b, want accum_out=%h overflow=%b",
                         e.name, e.id, acc_s[e.id], ovf_s[e.id], e.acc, e.ovf);
            end
        end
    end

    task automatic check(input string name, input logic [32:0] got,
                         input logic [32:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s: got %h, want %h", name, got, want);
        end
    endtask

    // Called just after a falling edge. It drives one lane and idles the rest,
    // then posts the response expected after the next rising edge.
    task automatic step(input int id, input logic clr, input logic en,
                        input logic [31:0] a, input logic [31:0] b,
                        input logic [31:0] exp_acc, input logic exp_ovf,
                        input string name);
        for (int i = 0; i < N; i++) begin
            clear_s[i]  = 1'b0;
            enable_s[i] = 1'b0;
        end
        clear_s[id]  = clr;
        enable_s[id] = en;
        a_s[id]      = a;
        b_s[id]      = b;
        @(posedge clk);
        sb.push_back('{id, exp_acc, exp_ovf, name});
        @(negedge clk);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, time=%0t required<200000", $time);
        $fatal(1);
    end

    initial begin
        reset = 1'b0;
        for (int i = 0; i < N; i++) begin
            clear_s[i]  = 1'b0;
            enable_s[i] = 1'b0;
            a_s[i]      = '0;
            b_s[i]      = '0;
        end
        repeat (2) @(negedge clk);
        reset = 1'b1;

        // Reset state
        step(0, 0, 0, 0, 0, 32'h0, 0, "reset_state");

        // Dot product, unsigned defaults
        step(0, 1, 1, 1, 4, 32'd4,  0, "dot_t1");
        step(0, 0, 1, 2, 5, 32'd14, 0, "dot_t2");
        step(0, 0, 1, 3, 6, 32'd32, 0, "dot_t3");

        // Clear alone, then idle
        step(0, 1, 0, 9, 9, 32'd0, 0, "clear_only");
        step(0, 0, 0, 9, 9, 32'd0, 0, "idle1");
        step(0, 0, 0, 9, 9, 32'd0, 0, "idle2");

        // Hold with random operands
        step(0, 1, 1, 7, 6, 32'd42, 0, "load42");
        for (int i = 0; i < 3; i++)
            step(0, 0, 0, $urandom, $urandom, 32'd42, 0, "hold_rand");

        // Reset mid-accumulation
        step(0, 1, 1, 5, 10, 32'd50, 0, "load50");
        clear_s[0]  = 1'b0;
        enable_s[0] = 1'b1;
        a_s[0]      = 1;
        b_s[0]      = 1;
        @(posedge clk);
        #2 reset = 1'b0;
        #1;
        checks++;
        if (acc_s[0] !== 32'h0) begin
            errors++;
            $display("FAIL reset_async_acc: got accum_out=%h, want 00000000", acc_s[0]);
        end
        checks++;
        if (ovf_s[0] !== 1'b0) begin
            errors++;
            $display("FAIL reset_async_ovf: got overflow=%b, want 0", ovf_s[0]);
        end
        for (int i = 0; i < N; i++)
            check($sformatf("reset_async_lane%0d", i), {ovf_s[i], acc_s[i]}, 33'h0);
        sb.push_back('{0, 32'h0, 1'b0, "reset_async"});
        @(negedge clk);
        enable_s[0] = 1'b0;
        reset       = 1'b1;
        step(0, 0, 0, 1, 1, 32'h0, 0, "post_reset1");
        step(0, 0, 0, 1, 1, 32'h0, 0, "post_reset2");

        // Unsigned wrap, sticky overflow
        step(0, 1, 1, 32'hFFFFFFFF, 1, 32'hFFFFFFFF, 0, "u_load_max");
        step(0, 0, 1, 1, 1, 32'h0, 1, "u_wrap");
        step(0, 0, 1, 1, 1, 32'h1, 1, "u_sticky");
        step(0, 1, 0, 0, 0, 32'h0, 0, "u_clear_ovf");
        step(0, 1, 1, 32'hFFFFFFFF, 2, 32'hFFFFFFFE, 1, "u_first_term_ovf");
        step(0, 1, 1, 1, 1, 32'h1, 0, "u_first_term_ok");

        // Signed saturation
        step(1, 1, 1, 32'h7FFFFFF0, 1, 32'h7FFFFFF0, 0, "s_load");
        step(1, 0, 1, 32'h20, 1, 32'h7FFFFFFF, 1, "s_sat_max");
        step(1, 0, 1, 32'hFFFFFFFF, 32'h10, 32'h7FFFFFEF, 1, "s_sat_sticky");
        // Signed negative products
        step(1, 1, 1, 32'hFFFFFFFD, 4, 32'hFFFFFFF4, 0, "s_neg1");
        step(1, 0, 1, 2, 5, 32'hFFFFFFFE, 0, "s_neg2");
        // Saturate at the minimum, then an oversized first term
        step(1, 1, 1, 32'h80000000, 1, 32'h80000000, 0, "s_load_min");
        step(1, 0, 1, 32'hFFFFFFFF, 1, 32'h80000000, 1, "s_sat_min");
        step(1, 1, 1, 32'h80000000, 32'hFFFFFFFF, 32'h7FFFFFFF, 1, "s_first_term_sat");

        // Signed wrap: a wrapped value feeds the next sum as stored
        step(2, 1, 1, 32'h7FFFFFFF, 1, 32'h7FFFFFFF, 0, "sw_load");
        step(2, 0, 1, 1, 1, 32'h80000000, 1, "sw_wrap_up");
        step(2, 0, 1, 32'hFFFFFFFF, 1, 32'h7FFFFFFF, 1, "sw_wrap_down");
        step(2, 1, 0, 0, 0, 32'h0, 0, "sw_clear");

        // Unsigned saturation
        step(3, 1, 1, 32'hFFFFFFF0, 1, 32'hFFFFFFF0, 0, "us_load");
        step(3, 0, 1, 32'h20, 1, 32'hFFFFFFFF, 1, "us_sat");
        step(3, 1, 1, 32'h10000, 32'h10000, 32'hFFFFFFFF, 1, "us_first_term_sat");
        step(3, 1, 1, 2, 3, 32'h6, 0, "us_first_term_ok");

        repeat (2) @(negedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
